// File: rtl/game_timer_bank.sv
// Bank of tick-driven timers (one-shot or periodic) plus a free-running seed counter.
// The raw 2 kHz tick is synchronised and edge-detected in the clk_50M domain.
module game_timer_bank #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned SEED_WIDTH = 12
) (
  input  logic                    clk_50M,
  input  logic                    i_Reset,
  input  logic                    i_Tick2K,
  input  logic [N_CH-1:0]         i_Start,
  input  logic [N_CH-1:0]         i_Stop,
  input  logic [N_CH-1:0]         i_Periodic,
  input  logic [N_CH*WIDTH-1:0]   i_Term,
  output logic [N_CH*WIDTH-1:0]   o_Count,
  output logic [N_CH-1:0]         o_Busy,
  output logic [N_CH-1:0]         o_Done,
  output logic [N_CH-1:0]         o_Expired,
  output logic [SEED_WIDTH-1:0]   o_Seed
);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} ch_state_e;

  // [0],[1] form the synchroniser; [2] is the previous synchronised level for edge detect.
  logic [2:0]            tick_sync_q;
  logic                  tick_q;
  logic [SEED_WIDTH-1:0] seed_q;

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      tick_sync_q <= '0;
      tick_q      <= 1'b0;
      seed_q      <= '0;
    end else begin
      tick_sync_q <= {tick_sync_q[1:0], i_Tick2K};
      tick_q      <= tick_sync_q[1] & ~tick_sync_q[2];
      seed_q      <= seed_q + SEED_WIDTH'(1);
    end
  end

  assign o_Seed = seed_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_e        state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] term_q;
    logic             periodic_q;
    logic             busy_q;
    logic             done_q;
    logic             expired_q;
    logic [WIDTH-1:0] count_inc;
    logic             expire;

    assign count_inc = count_q + WIDTH'(1);
    // A zero terminal expires on every tick, like a terminal of one with the count pinned at 0.
    assign expire    = (count_inc == term_q) || (term_q == '0);

    always_ff @(posedge clk_50M) begin
      if (i_Reset) begin
        state_q    <= StIdle;
        count_q    <= '0;
        term_q     <= '0;
        periodic_q <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
        expired_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (i_Stop[g]) begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          expired_q <= 1'b0;
        end else if (i_Start[g]) begin
          term_q     <= i_Term[g*WIDTH +: WIDTH];
          periodic_q <= i_Periodic[g];
          count_q    <= '0;
          expired_q  <= 1'b0;
          state_q    <= StRun;
          busy_q     <= 1'b1;
        end else if (state_q == StRun && tick_q) begin
          if (expire) begin
            done_q    <= 1'b1;
            expired_q <= 1'b1;
            if (periodic_q) begin
              count_q <= '0;
            end else begin
              count_q <= term_q;
              state_q <= StExpired;
              busy_q  <= 1'b0;
            end
          end else begin
            count_q <= count_inc;
          end
        end
      end
    end

    assign o_Count[g*WIDTH +: WIDTH] = count_q;
    assign o_Busy[g]                 = busy_q;
    assign o_Done[g]                 = done_q;
    assign o_Expired[g]              = expired_q;
  end

endmodule

// File: tb/tb_game_timer_bank.sv
// Bench for game_timer_bank: scenario table, hand-written corner sequences and a jittered
// random phase, all shadowed cycle by cycle by a flag-and-integer reference model.
module tb_game_timer_bank;
  localparam int W = 12;
  localparam int N = 2;
  localparam int SW = 12;

  logic             clk_50M = 1'b0;
  logic             rst = 1'b1;
  logic             raw = 1'b0;
  logic [N-1:0]     start = '1;
  logic [N-1:0]     stop = '0;
  logic [N-1:0]     per = '0;
  logic [N*W-1:0]   term = '0;
  logic [N*W-1:0]   o_Count;
  logic [N-1:0]     o_Busy, o_Done, o_Expired;
  logic [SW-1:0]    o_Seed;

  game_timer_bank #(.WIDTH(W), .N_CH(N), .SEED_WIDTH(SW)) dut (
    .clk_50M   (clk_50M),
    .i_Reset   (rst),
    .i_Tick2K  (raw),
    .i_Start   (start),
    .i_Stop    (stop),
    .i_Periodic(per),
    .i_Term    (term),
    .o_Count   (o_Count),
    .o_Busy    (o_Busy),
    .o_Done    (o_Done),
    .o_Expired (o_Expired),
    .o_Seed    (o_Seed)
  );

  always #10 clk_50M = ~clk_50M;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raw-level history, per-channel running/expired flags and integer counts.
  logic [4:0] hist = '0;
  bit  m_run[N], m_exp[N], m_done[N], m_per[N];
  int  m_cnt[N], m_term[N];
  int  m_seed = 0;
  int  done_seen[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick;
    hist = {hist[3:0], raw};
    // A raw rising edge sampled at edge n-3 is counted at edge n.
    tick = hist[3] & ~hist[4];
    if (rst) begin
      hist = '0;
      m_seed = 0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_exp[c] = 0; m_done[c] = 0; m_per[c] = 0; m_cnt[c] = 0; m_term[c] = 0;
      end
    end else begin
      m_seed = (m_seed + 1) % (1 << SW);
      for (int c = 0; c < N; c++) begin
        m_done[c] = 0;
        if (stop[c]) begin
          m_run[c] = 0; m_exp[c] = 0;
        end else if (start[c]) begin
          m_term[c] = int'(term[c*W +: W]); m_per[c] = per[c];
          m_cnt[c] = 0; m_exp[c] = 0; m_run[c] = 1;
        end else if (m_run[c] && tick) begin
          if (m_cnt[c] + 1 == m_term[c] || m_term[c] == 0) begin
            m_done[c] = 1; m_exp[c] = 1;
            if (m_per[c]) m_cnt[c] = 0;
            else begin m_cnt[c] = m_term[c]; m_run[c] = 0; end
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N*W-1:0] ec;
    logic [N-1:0] eb, ed, ee;
    for (int c = 0; c < N; c++) begin
      ec[c*W +: W] = m_cnt[c][W-1:0];
      eb[c] = m_run[c]; ed[c] = m_done[c]; ee[c] = m_exp[c];
      if (o_Done[c] === 1'b1) done_seen[c]++;
    end
    chk("model_count", 32'(o_Count), 32'(ec));
    chk("model_busy", 32'(o_Busy), 32'(eb));
    chk("model_done", 32'(o_Done), 32'(ed));
    chk("model_expired", 32'(o_Expired), 32'(ee));
    chk("model_seed", 32'(o_Seed), 32'(m_seed));
  endtask

  task automatic cycle();
    @(posedge clk_50M);
    model_step();
    #1;
    check_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      raw = 1'b1; cycle();
      raw = 1'b0; cycle();
    end
  endtask

  task automatic drain();
    raw = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic start_ch(input int c, input int t, input bit p);
    term[c*W +: W] = t[W-1:0];
    per[c] = p;
    start[c] = 1'b1;
    cycle();
    start[c] = 1'b0;
    done_seen[c] = 0;
  endtask

  typedef struct {
    int ch; int t; bit p; int nticks;
    int exp_cnt; bit exp_expired; bit exp_busy; int exp_dones;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 4000, 0, 4000, 4000, 1, 0, 1};
    tbl[1] = '{0, 10,   0, 5,    5,    0, 1, 0};
    tbl[2] = '{1, 3,    1, 9,    0,    1, 1, 3};
    tbl[3] = '{1, 3,    1, 7,    1,    1, 1, 2};
    tbl[4] = '{0, 0,    0, 1,    0,    1, 0, 1};
    tbl[5] = '{0, 0,    1, 5,    0,    1, 1, 5};
    tbl[6] = '{0, 1,    0, 3,    1,    1, 0, 1};
    tbl[7] = '{1, 5,    0, 5,    5,    1, 0, 1};
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_exp[c] = 0; m_done[c] = 0; m_per[c] = 0; m_cnt[c] = 0; m_term[c] = 0;
      done_seen[c] = 0;
    end

    // Reset dominates start; seed counts from 0 after release.
    repeat (3) cycle();
    chk("reset_busy", 32'(o_Busy), 0);
    chk("reset_count", 32'(o_Count), 0);
    chk("reset_seed", 32'(o_Seed), 0);
    rst = 1'b0; start = '0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("seed_after_reset", 32'(o_Seed), 32'(i));
    end
    drain();

    for (int i = 0; i < $size(tbl); i++) begin
      start_ch(tbl[i].ch, tbl[i].t, tbl[i].p);
      tick_n(tbl[i].nticks);
      drain();
      chk("tbl_count", 32'(o_Count[tbl[i].ch*W +: W]), 32'(tbl[i].exp_cnt));
      chk("tbl_expired", 32'(o_Expired[tbl[i].ch]), 32'(tbl[i].exp_expired));
      chk("tbl_busy", 32'(o_Busy[tbl[i].ch]), 32'(tbl[i].exp_busy));
      chk("tbl_dones", 32'(done_seen[tbl[i].ch]), 32'(tbl[i].exp_dones));
    end

    // Stop at count 5: held, idle, no done.
    start_ch(0, 20, 0);
    tick_n(5);
    drain();
    stop[0] = 1'b1; cycle(); stop[0] = 1'b0;
    chk("stop_count", 32'(o_Count[W-1:0]), 5);
    chk("stop_busy", 32'(o_Busy[0]), 0);
    chk("stop_expired", 32'(o_Expired[0]), 0);
    chk("stop_dones", 32'(done_seen[0]), 0);

    // Start and stop together: stop wins.
    start[0] = 1'b1; stop[0] = 1'b1; cycle(); start[0] = 1'b0; stop[0] = 1'b0;
    chk("startstop_busy", 32'(o_Busy[0]), 0);
    chk("startstop_count", 32'(o_Count[W-1:0]), 5);

    // Restart landing on the same edge as a tick: tick ignored.
    start_ch(0, 20, 0);
    tick_n(3);
    drain();
    chk("pre_coincide_count", 32'(o_Count[W-1:0]), 3);
    raw = 1'b1; cycle(); cycle(); cycle();
    start[0] = 1'b1; cycle(); start[0] = 1'b0;
    chk("coincide_count", 32'(o_Count[W-1:0]), 0);
    chk("coincide_busy", 32'(o_Busy[0]), 1);
    drain();

    // Reset mid-run with ticks still in flight.
    start_ch(1, 50, 1);
    tick_n(4);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("midreset_busy", 32'(o_Busy), 0);
    chk("midreset_count", 32'(o_Count), 0);
    chk("midreset_done", 32'(o_Done), 0);
    chk("midreset_expired", 32'(o_Expired), 0);
    drain();

    // Seed wrap.
    begin
      int guard = 0;
      while (m_seed != (1 << SW) - 1 && guard < 5000) begin cycle(); guard++; end
      if (guard >= 5000) chk("seed_wrap_timeout", 32'(guard), 0);
      cycle();
      chk("seed_wrap", 32'(o_Seed), 0);
    end

    // Random phase with jittered, variable-duty raw tick.
    begin
      int ph = 0, plen = 10, phigh = 5;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (ph == 0) begin
          plen = $urandom_range(8, 16);
          phigh = $urandom_range((plen * 3 + 9) / 10, (plen * 7) / 10);
        end
        for (int c = 0; c < N; c++) begin
          int t;
          start[c] = ($urandom_range(0, 39) == 0);
          stop[c] = ($urandom_range(0, 59) == 0);
          per[c] = $urandom_range(0, 1);
          t = $urandom_range(0, 7);
          term[c*W +: W] = t[W-1:0];
        end
        rst = ($urandom_range(0, 999) == 0);
        #($urandom_range(0, 14));
        raw = (ph < phigh);
        ph = (ph + 1 == plen) ? 0 : ph + 1;
        cycle();
      end
      start = '0; stop = '0; rst = 1'b0;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
